// File: rtl/dcache_refill_ctrl.sv
// rtl/dcache_refill_ctrl.sv - data-cache miss sequencer: dirty-victim writeback, line refill, stall and statistics
module dcache_refill_ctrl #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int CNT_W         = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     miss_req_i,
   input  logic                     dirty_i,
   input  logic [31:0]              victim_addr_i,
   input  logic [31:0]              refill_addr_i,
   output logic [LINE_ADDR_LEN-1:0] wb_rd_idx_o,
   input  logic [31:0]              wb_rd_data_i,
   output logic                     refill_we_o,
   output logic [LINE_ADDR_LEN-1:0] refill_idx_o,
   output logic [31:0]              refill_data_o,
   output logic                     done_o,
   output logic                     busy_o,
   output logic                     stall_o,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [31:0]              mem_addr_o,
   output logic [31:0]              mem_wdata_o,
   input  logic                     mem_ack_i,
   input  logic [31:0]              mem_rdata_i,
   output logic [CNT_W-1:0]         miss_cnt_o,
   output logic [CNT_W-1:0]         wb_cnt_o
);

   localparam int OFF_W = LINE_ADDR_LEN + 2;
   localparam logic [31:0]              LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);
   localparam logic [LINE_ADDR_LEN-1:0] IDX_ONE   = LINE_ADDR_LEN'(1);
   localparam logic [LINE_ADDR_LEN-1:0] IDX_LAST  = '1;
   localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]         CNT_MAX   = '1;

   typedef enum logic [1:0] {S_IDLE, S_WB, S_RF, S_DONE} state_e;

   state_e                   state_q, state_d;
   logic [LINE_ADDR_LEN-1:0] idx_q, idx_d;
   logic [31:0]              base_wb_q, base_wb_d;
   logic [31:0]              base_rf_q, base_rf_d;
   logic [CNT_W-1:0]         miss_cnt_q, miss_cnt_d;
   logic [CNT_W-1:0]         wb_cnt_q, wb_cnt_d;
   logic [31:0]              word_off;

   // Word offset stays inside the line: bases have their low OFF_W bits cleared, so OR never carries.
   assign word_off = 32'({idx_q, 2'b00});

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         base_wb_q  <= '0;
         base_rf_q  <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         base_wb_q  <= base_wb_d;
         base_rf_q  <= base_rf_d;
         miss_cnt_q <= miss_cnt_d;
         wb_cnt_q   <= wb_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      base_wb_d     = base_wb_q;
      base_rf_d     = base_rf_q;
      miss_cnt_d    = miss_cnt_q;
      wb_cnt_d      = wb_cnt_q;
      refill_we_o   = 1'b0;
      refill_data_o = '0;
      done_o        = 1'b0;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = '0;
      mem_wdata_o   = '0;
      case (state_q)
         S_IDLE: begin
            if (miss_req_i) begin
               base_wb_d = victim_addr_i & LINE_MASK;
               base_rf_d = refill_addr_i & LINE_MASK;
               idx_d     = '0;
               state_d   = dirty_i ? S_WB : S_RF;
            end
         end
         S_WB: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = base_wb_q | word_off;
            mem_wdata_o = wb_rd_data_i;
            if (mem_ack_i) begin
               idx_d = idx_q + IDX_ONE;
               if (idx_q == IDX_LAST) begin
                  state_d  = S_RF;
                  wb_cnt_d = (wb_cnt_q == CNT_MAX) ? wb_cnt_q : wb_cnt_q + CNT_ONE;
               end
            end
         end
         S_RF: begin
            mem_req_o     = 1'b1;
            mem_addr_o    = base_rf_q | word_off;
            refill_we_o   = mem_ack_i;
            refill_data_o = mem_rdata_i;
            if (mem_ack_i) begin
               idx_d = idx_q + IDX_ONE;
               if (idx_q == IDX_LAST) begin
                  state_d    = S_DONE;
                  miss_cnt_d = (miss_cnt_q == CNT_MAX) ? miss_cnt_q : miss_cnt_q + CNT_ONE;
               end
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign wb_rd_idx_o  = idx_q;
   assign refill_idx_o = idx_q;
   assign busy_o       = (state_q != S_IDLE);
   // Low in DONE so the frozen access re-issues and hits the freshly installed line.
   assign stall_o      = (miss_req_i & (state_q == S_IDLE)) | (state_q == S_WB) | (state_q == S_RF);
   assign miss_cnt_o   = miss_cnt_q;
   assign wb_cnt_o     = wb_cnt_q;

endmodule
